da_tx: RTL and testbench

DA_TX -- requirements
Module: da_tx

---
 rtl/da_tx.sv | 153 +++++++++++++++
 tb/tb_da_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_tx.sv
`default_nettype none
// ============================================================================
// Module   : da_tx
// Brief    : Dual-channel DAC streamer, sample FIFO, rate-divided bit-reversed
//            pin output with latch strobe and underflow reporting.
// Revision : 1.0
// ============================================================================
module da_tx #(
  parameter int          DEPTH = 16,
  parameter logic [11:0] MID   = 12'h800
) (
  input  logic                     da_clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [7:0]               rate_div,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [11:0]              s_ch1,
  input  logic [11:0]              s_ch2,
  output logic [11:0]              da1_out,
  output logic [11:0]              da2_out,
  output logic                     da_wrt,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int          AW     = $clog2(DEPTH);
  localparam int          HALF_I = DEPTH / 2;
  localparam logic [AW:0] HALF   = HALF_I[AW:0];
  localparam logic [AW:0] FULL   = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [11:0] bitrev(input logic [11:0] v);
    logic [11:0] r;
    for (int i = 0; i < 12; i++) r[i] = v[11-i];
    return r;
  endfunction

  localparam logic [11:0] MID_PIN = bitrev(MID);

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] da1_q, da1_d;
  logic [11:0] da2_q, da2_d;
  logic        wrt_q, wrt_d;
  logic        uf_q, uf_d;
  logic [23:0] mem_q [DEPTH];

  logic [AW:0] level;
  logic        empty;
  logic        tick;
  logic        push;
  logic        pop;
  logic [23:0] head;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign s_ready = (state_q != IDLE) && (level != FULL);
  assign tick    = (state_q == RUN) && (cnt_q >= rate_div);
  assign push    = s_valid && s_ready && en;
  assign pop     = tick && !empty && en;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    da1_d    = da1_q;
    da2_d    = da2_q;
    wrt_d    = 1'b0;
    uf_d     = 1'b0;
    if (!en) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      da1_d    = MID_PIN;
      da2_d    = MID_PIN;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = PRIME;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          da1_d    = MID_PIN;
          da2_d    = MID_PIN;
        end
        PRIME: begin
          if (level >= HALF) state_d = RUN;
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        end
        RUN: begin
          cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            da1_d    = bitrev(head[23:12]);
            da2_d    = bitrev(head[11:0]);
            wrt_d    = 1'b1;
          end else if (tick) begin
            uf_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge da_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      da1_q    <= MID_PIN;
      da2_q    <= MID_PIN;
      wrt_q    <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      da1_q    <= da1_d;
      da2_q    <= da2_d;
      wrt_q    <= wrt_d;
      uf_q     <= uf_d;
    end
  end

  // Storage needs no reset; occupancy is defined solely by the pointers.
  always_ff @(posedge da_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_ch1, s_ch2};
  end

  assign da1_out    = da1_q;
  assign da2_out    = da2_q;
  assign da_wrt     = wrt_q;
  assign underflow  = uf_q;
  assign fifo_level = level;

endmodule
`default_nettype wire

// File: tb/tb_da_tx.sv
`default_nettype none
// Randomized bench for da_tx: queue-based behavioural model compared every
// cycle, plus literal expectations for reset, reversal, underflow and abort.
module tb_da_tx;

  localparam int          DEPTH = 16;
  localparam logic [11:0] MID   = 12'h800;

  logic        da_clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  rate_div;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_ch1;
  logic [11:0] s_ch2;
  logic [11:0] da1_out;
  logic [11:0] da2_out;
  logic        da_wrt;
  logic        underflow;
  logic [4:0]  fifo_level;

  int checks;
  int failures;

  da_tx #(.DEPTH(DEPTH), .MID(MID)) dut (
    .da_clk(da_clk), .rst_n(rst_n), .en(en), .rate_div(rate_div),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch1(s_ch1), .s_ch2(s_ch2),
    .da1_out(da1_out), .da2_out(da2_out), .da_wrt(da_wrt),
    .underflow(underflow), .fifo_level(fifo_level)
  );

  initial begin
    da_clk = 1'b0;
    forever #5 da_clk = ~da_clk;
  end

  function automatic logic [11:0] rev12(input logic [11:0] v);
    logic [11:0] r;
    for (int i = 0; i < 12; i++) r[i] = v[11-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=priming, 2=streaming.
  logic [23:0] mq[$];
  int          mstate;
  int          mcnt;
  logic [11:0] md1, md2;
  logic        mwrt, muf;
  logic        m_rdy, m_push;
  logic [23:0] m_din, m_head;

  always @(posedge da_clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mstate = 0;
      mcnt   = 0;
      md1    = rev12(MID);
      md2    = rev12(MID);
      mwrt   = 1'b0;
      muf    = 1'b0;
    end else begin
      m_rdy  = (mstate != 0) && (mq.size() != DEPTH);
      m_push = s_valid && m_rdy;
      m_din  = {s_ch1, s_ch2};
      mwrt   = 1'b0;
      muf    = 1'b0;
      if (!en) begin
        mstate = 0;
        mq.delete();
        mcnt = 0;
        md1  = rev12(MID);
        md2  = rev12(MID);
      end else if (mstate == 0) begin
        mstate = 1;
      end else if (mstate == 1) begin
        if (mq.size() >= DEPTH / 2) mstate = 2;
        if (m_push) mq.push_back(m_din);
      end else begin
        if (mcnt >= int'(rate_div)) begin
          mcnt = 0;
          if (mq.size() > 0) begin
            m_head = mq.pop_front();
            md1    = rev12(m_head[23:12]);
            md2    = rev12(m_head[11:0]);
            mwrt   = 1'b1;
          end else begin
            muf = 1'b1;
          end
        end else begin
          mcnt++;
        end
        if (m_push) mq.push_back(m_din);
      end
    end
  end

  always @(negedge da_clk) begin
    check("s_ready", 32'(s_ready), 32'((mstate != 0) && (mq.size() != DEPTH)));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("da1_out", 32'(da1_out), 32'(md1));
    check("da2_out", 32'(da2_out), 32'(md2));
    check("da_wrt", 32'(da_wrt), 32'(mwrt));
    check("underflow", 32'(underflow), 32'(muf));
    check("wrt_uf_exclusive", 32'(da_wrt && underflow), 32'd0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge da_clk);
    #1;
  endtask

  task automatic push_pair(input logic [11:0] a, input logic [11:0] b);
    logic r;
    logic got;
    s_valid = 1'b1;
    s_ch1   = a;
    s_ch2   = b;
    got     = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge da_clk);
      r = s_ready;
      @(posedge da_clk);
      #1;
      got = r;
    end
    if (!got) check("push_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_wrt(input int bound, output int ncyc, output logic found);
    found = 1'b0;
    ncyc  = 0;
    for (int k = 1; k <= bound && !found; k++) begin
      @(negedge da_clk);
      if (da_wrt) begin
        found = 1'b1;
        ncyc  = k;
      end
    end
  endtask

  int   ncyc, nwrt, nuf, maxlev, minlev;
  logic found;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; rate_div = 8'd0;
    s_ch1 = 12'h0; s_ch2 = 12'h0;

    // Reset and idle
    step(3);
    @(negedge da_clk);
    check("rst_da1", 32'(da1_out), 32'h001);
    check("rst_da2", 32'(da2_out), 32'h001);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(10);
    @(negedge da_clk);
    check("idle_da1", 32'(da1_out), 32'h001);
    check("idle_ready", 32'(s_ready), 32'd0);

    // Prime and bit reversal
    step(1);
    en = 1'b1; rate_div = 8'd3;
    push_pair(12'h001, 12'hA5C);
    for (int i = 0; i < 7; i++) push_pair(12'($urandom), 12'($urandom));
    s_valid = 1'b0;
    wait_wrt(100, ncyc, found);
    check("first_wrt_seen", 32'(found), 32'd1);
    check("first_da1", 32'(da1_out), 32'h800);
    check("first_da2", 32'(da2_out), 32'h3A5);
    for (int i = 0; i < 3; i++) begin
      wait_wrt(20, ncyc, found);
      check("wrt_period", 32'(ncyc), 32'd4);
    end

    // Underflow at rate_div=0
    step(1);
    en = 1'b0;
    step(1);
    en = 1'b1; rate_div = 8'd0;
    for (int i = 0; i < 7; i++) push_pair(12'($urandom), 12'($urandom));
    push_pair(12'h00F, 12'hF00);
    s_valid = 1'b0;
    nwrt = 0; nuf = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge da_clk);
      if (da_wrt) nwrt++;
      if (underflow) nuf++;
    end
    check("uf_wrt_count", 32'(nwrt), 32'd8);
    check("uf_pulses_ge15", 32'(nuf >= 15), 32'd1);
    check("uf_hold_da1", 32'(da1_out), 32'hF00);
    check("uf_hold_da2", 32'(da2_out), 32'h00F);
    check("uf_still_ready", 32'(s_ready), 32'd1);

    // Full / backpressure at rate_div=255
    step(1);
    en = 1'b0;
    step(1);
    en = 1'b1; rate_div = 8'd255; s_valid = 1'b1;
    maxlev = 0; minlev = 99;
    for (int i = 0; i < 700; i++) begin
      s_ch1 = 12'($urandom); s_ch2 = 12'($urandom);
      @(negedge da_clk);
      if (int'(fifo_level) > maxlev) maxlev = int'(fifo_level);
      if (i >= 40 && int'(fifo_level) < minlev) minlev = int'(fifo_level);
      step(1);
    end
    s_valid = 1'b0;
    check("full_max_level", 32'(maxlev), 32'd16);
    check("full_min_level", 32'(minlev), 32'd15);

    // Abort on a tick cycle with level 10
    en = 1'b0;
    step(1);
    en = 1'b1; rate_div = 8'd7;
    for (int i = 0; i < 12; i++) push_pair(12'($urandom), 12'($urandom));
    s_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge da_clk);
      if (mstate == 2 && mcnt >= int'(rate_div) && mq.size() == 10) found = 1'b1;
    end
    check("abort_point_found", 32'(found), 32'd1);
    en = 1'b0;
    @(negedge da_clk);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_da1", 32'(da1_out), 32'h001);
    check("abort_da2", 32'(da2_out), 32'h001);
    check("abort_wrt", 32'(da_wrt), 32'd0);
    check("abort_ready", 32'(s_ready), 32'd0);

    // Randomized traffic
    step(1);
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 99) != 0);
      s_valid = 1'($urandom_range(0, 1));
      s_ch1   = 12'($urandom);
      s_ch2   = 12'($urandom);
      if (i % 100 == 0) rate_div = 8'($urandom_range(0, 5));
      step(1);
    end

    // Asynchronous reset mid-stream
    en = 1'b1; rate_div = 8'd2; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_ch1 = 12'($urandom); s_ch2 = 12'($urandom);
      step(1);
    end
    @(negedge da_clk);
    check("pre_rst_level_nonzero", 32'(fifo_level != 0), 32'd1);
    @(posedge da_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_da1", 32'(da1_out), 32'h001);
    check("arst_da2", 32'(da2_out), 32'h001);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_ready", 32'(s_ready), 32'd0);
    check("arst_wrt", 32'(da_wrt), 32'd0);
    s_valid = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
